// File: rtl/hdmi_cell_averager.sv
// rtl/hdmi_cell_averager.sv - per-cell RGB averaging of an HDMI pixel stream into a small output FIFO
// Optional round-half-up averaging with saturation when HDMI_CELL_AVERAGER_ROUND_EN is defined.
module hdmi_cell_averager #(
  parameter int CELLS_X     = 8,
  parameter int CELLS_Y     = 8,
  parameter int CELL_W_LOG2 = 4,
  parameter int CELL_H_LOG2 = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        rgb_valid,
  input  logic [11:0] xaddr,
  input  logic [11:0] yaddr,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_cx,
  output logic [4:0]  out_cy,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        frame_done,
  output logic        overflow
);

  localparam int SHIFT = CELL_W_LOG2 + CELL_H_LOG2;
  localparam int SW    = 8 + SHIFT;
  localparam int CXW   = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW    = 34;

  function automatic logic [7:0] cell_avg(input logic [SW-1:0] s);
`ifdef HDMI_CELL_AVERAGER_ROUND_EN
    logic [8:0] t;
    // Adding half an LSB before the shift equals adding the first dropped bit after it.
    t = {1'b0, s[SW-1:SHIFT]} + 9'(s[SHIFT-1]);
    return t[8] ? 8'hff : t[7:0];
`else
    return s[SW-1:SHIFT];
`endif
  endfunction

  logic [11:0]    cx_full, cy_full;
  logic [CXW-1:0] cx_idx;
  logic           in_grid, first_px, last_px;
  logic [SW-1:0]  sum_r, sum_g, sum_b;

  logic [SW-1:0]  acc_r_q [CELLS_X];
  logic [SW-1:0]  acc_g_q [CELLS_X];
  logic [SW-1:0]  acc_b_q [CELLS_X];
  logic [SW-1:0]  acc_r_d [CELLS_X];
  logic [SW-1:0]  acc_g_d [CELLS_X];
  logic [SW-1:0]  acc_b_d [CELLS_X];
  logic           vsync_q, vsync_d;

  logic           emit_q, emit_d;
  logic [EW-1:0]  emit_ent_q, emit_ent_d;

  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [EW-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           push, pop, full, do_write;

  assign cx_full  = xaddr >> CELL_W_LOG2;
  assign cy_full  = yaddr >> CELL_H_LOG2;
  assign cx_idx   = cx_full[CXW-1:0];
  assign in_grid  = rgb_valid && (cx_full < 12'(CELLS_X)) && (cy_full < 12'(CELLS_Y));
  assign first_px = (xaddr[CELL_W_LOG2-1:0] == '0) && (yaddr[CELL_H_LOG2-1:0] == '0);
  assign last_px  = (&xaddr[CELL_W_LOG2-1:0]) && (&yaddr[CELL_H_LOG2-1:0]);
  assign sum_r    = acc_r_q[cx_idx] + SW'(r);
  assign sum_g    = acc_g_q[cx_idx] + SW'(g);
  assign sum_b    = acc_b_q[cx_idx] + SW'(b);

  always_comb begin
    acc_r_d    = acc_r_q;
    acc_g_d    = acc_g_q;
    acc_b_d    = acc_b_q;
    vsync_d    = vsync;
    emit_d     = 1'b0;
    emit_ent_d = emit_ent_q;
    if (vsync && !vsync_q) begin
      for (int i = 0; i < CELLS_X; i++) begin
        acc_r_d[i] = '0;
        acc_g_d[i] = '0;
        acc_b_d[i] = '0;
      end
    end else if (in_grid) begin
      if (first_px) begin
        acc_r_d[cx_idx] = SW'(r);
        acc_g_d[cx_idx] = SW'(g);
        acc_b_d[cx_idx] = SW'(b);
      end else begin
        acc_r_d[cx_idx] = sum_r;
        acc_g_d[cx_idx] = sum_g;
        acc_b_d[cx_idx] = sum_b;
      end
    end
    if (in_grid && last_px) begin
      emit_d     = 1'b1;
      emit_ent_d = {5'(cx_full), 5'(cy_full), cell_avg(sum_r), cell_avg(sum_g), cell_avg(sum_b)};
    end
  end

  assign push     = emit_q;
  assign pop      = out_valid && out_ready;
  assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_write = push && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push && !do_write) ovf_d = 1'b1;
    if (do_write) begin
      mem_d[wr_q] = emit_ent_q;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (do_write && !pop) cnt_d = cnt_q + 1'b1;
    else if (!do_write && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CELLS_X; i++) begin
        acc_r_q[i] <= '0;
        acc_g_q[i] <= '0;
        acc_b_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      vsync_q    <= 1'b0;
      emit_q     <= 1'b0;
      emit_ent_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      acc_r_q    <= acc_r_d;
      acc_g_q    <= acc_g_d;
      acc_b_q    <= acc_b_d;
      mem_q      <= mem_d;
      vsync_q    <= vsync_d;
      emit_q     <= emit_d;
      emit_ent_q <= emit_ent_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign {out_cx, out_cy, out_r, out_g, out_b} = mem_q[rd_q];
  assign frame_done = emit_q && (emit_ent_q[33:29] == 5'(CELLS_X-1)) && (emit_ent_q[28:24] == 5'(CELLS_Y-1));
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_hdmi_cell_averager.sv
// tb/tb_hdmi_cell_averager.sv - directed vector bench for hdmi_cell_averager (2x2 grid of 4x4 cells)
module tb_hdmi_cell_averager;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync = 1'b0;
  logic        rgb_valid = 1'b0;
  logic [11:0] xaddr = '0, yaddr = '0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [4:0]  out_cx, out_cy;
  logic [7:0]  out_r, out_g, out_b;
  logic        frame_done, overflow;

  int errors = 0;
  int checks = 0;

  hdmi_cell_averager #(
    .CELLS_X(2), .CELLS_Y(2), .CELL_W_LOG2(2), .CELL_H_LOG2(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .rgb_valid(rgb_valid),
    .xaddr(xaddr), .yaddr(yaddr), .r(r), .g(g), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cx(out_cx), .out_cy(out_cy), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r, g, b, rl;
    logic [7:0] er_trunc, er_round, eg, eb;
  } vec_t;

  vec_t vecs[5];

  logic [33:0] got[$];
  int fd_cnt = 0;
  int fd_pops = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back({out_cx, out_cy, out_r, out_g, out_b});
    if (frame_done) begin
      fd_cnt  = fd_cnt + 1;
      fd_pops = got.size();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    out_ready = 1'b0;
    rgb_valid = 1'b0;
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    got.delete();
    fd_cnt = 0;
  endtask

  task automatic pulse_vsync();
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
  endtask

  // Raster over lines y0..y1-1, columns 0..xn-1; oog adds two r/g/b=255 pixels beyond the grid per line.
  task automatic drive(input int xn, input int y0, input int y1,
                       input int pr, input int pg, input int pb, input int plast,
                       input int inc, input bit oog);
    int idx;
    for (int y = y0; y < y1; y++) begin
      for (int x = 0; x < xn + (oog ? 2 : 0); x++) begin
        @(posedge clk); #1;
        rgb_valid = 1'b1;
        xaddr = 12'(x);
        yaddr = 12'(y);
        if (x >= xn) begin
          r = 8'hff; g = 8'hff; b = 8'hff;
        end else begin
          idx = (x >> 2) + 2 * (y >> 2);
          r = ((x & 3) == 3 && (y & 3) == 3) ? 8'(plast + inc * idx) : 8'(pr + inc * idx);
          g = 8'(pg);
          b = 8'(pb);
        end
      end
    end
    @(posedge clk); #1 rgb_valid = 1'b0;
  endtask

  task automatic check_entry(input string name, input int i, input int ecx, input int ecy,
                             input int er, input int eg, input int eb);
    logic [33:0] e;
    if (i >= got.size()) begin
      chk({name, "_present"}, got.size(), i + 1);
      return;
    end
    e = got[i];
    chk({name, "_cx"}, int'(e[33:29]), ecx);
    chk({name, "_cy"}, int'(e[28:24]), ecy);
    chk({name, "_r"},  int'(e[23:16]), er);
    chk({name, "_g"},  int'(e[15:8]),  eg);
    chk({name, "_b"},  int'(e[7:0]),   eb);
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int er;
`ifdef HDMI_CELL_AVERAGER_ROUND_EN
    er = int'(v.er_round);
`else
    er = int'(v.er_trunc);
`endif
    got.delete();
    fd_cnt = 0;
    out_ready = 1'b1;
    pulse_vsync();
    drive(8, 0, 8, int'(v.r), int'(v.g), int'(v.b), int'(v.rl), 0, 1'b1);
    repeat (6) @(posedge clk);
    chk({name, "_count"}, got.size(), 4);
    for (int i = 0; i < 4; i++) check_entry(name, i, i % 2, i / 2, er, int'(v.eg), int'(v.eb));
    chk({name, "_frame_done_cnt"}, fd_cnt, 1);
    chk({name, "_frame_done_at_4th"}, fd_pops, 3);
  endtask

  initial begin
    vecs[0] = '{r:10,  g:20,  b:30,  rl:10,  er_trunc:10,  er_round:10,  eg:20,  eb:30};
    vecs[1] = '{r:0,   g:0,   b:0,   rl:15,  er_trunc:0,   er_round:1,   eg:0,   eb:0};
    vecs[2] = '{r:100, g:7,   b:200, rl:108, er_trunc:100, er_round:101, eg:7,   eb:200};
    vecs[3] = '{r:1,   g:2,   b:3,   rl:9,   er_trunc:1,   er_round:2,   eg:2,   eb:3};
    vecs[4] = '{r:255, g:255, b:255, rl:255, er_trunc:255, er_round:255, eg:255, eb:255};

    do_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_cx", out_cx, 0);
    chk("rst_out_cy", out_cy, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_g", out_g, 0);
    chk("rst_out_b", out_b, 0);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
    chk("vec_overflow", overflow, 0);

    // Backpressure: six cells into a four-deep FIFO.
    do_reset();
    drive(8, 0, 8, 40, 5, 6, 40, 1, 1'b0);
    pulse_vsync();
    drive(8, 0, 4, 60, 5, 6, 60, 1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_overflow", overflow, 1);
    chk("bp_head_r", out_r, 40);
    chk("bp_head_cx", out_cx, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_drain_count", got.size(), 4);
    for (int i = 0; i < 4; i++) check_entry("bp", i, i % 2, i / 2, 40 + i, 5, 6);
    chk("bp_empty_after", out_valid, 0);

    // Full FIFO with a pop in the very cycle a new cell is pushed.
    do_reset();
    drive(8, 0, 8, 40, 5, 6, 40, 1, 1'b0);
    repeat (3) @(posedge clk);
    pulse_vsync();
    drive(4, 0, 4, 60, 5, 6, 60, 1, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("fp_overflow", overflow, 0);
    chk("fp_head_r", out_r, 41);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("fp_total", got.size(), 5);
    check_entry("fp0", 0, 0, 0, 40, 5, 6);
    check_entry("fp1", 1, 1, 0, 41, 5, 6);
    check_entry("fp2", 2, 0, 1, 42, 5, 6);
    check_entry("fp3", 3, 1, 1, 43, 5, 6);
    check_entry("fp4", 4, 0, 0, 60, 5, 6);

    // vsync rising edge discards a half-accumulated cell.
    do_reset();
    out_ready = 1'b1;
    drive(4, 0, 2, 32, 32, 32, 32, 0, 1'b0);
    pulse_vsync();
    drive(4, 2, 4, 32, 32, 32, 32, 0, 1'b0);
    repeat (4) @(posedge clk);
    chk("vs_count", got.size(), 1);
    check_entry("vs", 0, 0, 0, 16, 16, 16);

    // Asynchronous reset mid-cell with entries pending and overflow set.
    do_reset();
    drive(8, 0, 8, 40, 5, 6, 40, 1, 1'b0);
    pulse_vsync();
    drive(4, 0, 4, 60, 5, 6, 60, 1, 1'b0);
    drive(4, 0, 2, 70, 5, 6, 70, 0, 1'b0);
    @(negedge clk);
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_overflow", overflow, 1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_overflow", overflow, 0);
    chk("ar_frame_done", frame_done, 0);
    chk("ar_out_r", out_r, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    run_frame(vecs[0], "ar_frame");
    chk("ar_overflow_after", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
